nexys_video_basic_io_v2: RTL and testbench
==========================================

NEXYS_VIDEO_BASIC_IO_V2 -- requirements
Module: nexys_video_basic_io_v2

Interface
REQ-001 SHALL have parameter AXI_ID_WIDTH, default 1, AXI ID width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 64, AXI address width.
REQ-003 SHALL have parameter AXI_DATA_WIDTH, default 64, AXI data width; legal values are 32 and 64.
REQ-004 SHALL have parameter NUM_BUTTONS, default 5, button count (1..32).
REQ-005 SHALL have parameter NUM_SWITCHES, default 8, switch count (1..32).
REQ-006 SHALL have parameter NUM_LEDS, default 8, LED count (1..32).
REQ-007 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, required stable cycles (>=1).
REQ-008 SHALL have port aclk, input, 1, sole clock.
REQ-009 SHALL have port areset, input, 1, asynchronous active-low reset.
REQ-010 SHALL have the AXI-Lite subordinate ports i_awvalid/o_awready/i_awid/i_awaddr/i_awprot, i_wvalid/o_wready/i_wdata/i_wstrb, o_bvalid/i_bready/o_bid/o_bresp[1:0], i_arvalid/o_arready/i_arid/i_araddr/i_arprot, and o_rvalid/i_rready/o_rid/o_rdata/o_rresp[1:0], each sized by the AXI parameters.
REQ-011 SHALL have port i_buttons, input, NUM_BUTTONS, raw asynchronous buttons.
REQ-012 SHALL have port i_switches, input, NUM_SWITCHES, raw asynchronous switches.
REQ-013 SHALL have port o_leds, output, NUM_LEDS, LED drive.
REQ-014 SHALL have port o_irq, output, 1, level interrupt.

Function
REQ-015 SHALL decode registers at 8-byte stride using addr[5:3] and ignore all other address bits: 0x00 LED (RW), 0x08 SWITCH (RO), 0x10 BUTTON (RO), 0x18 EVENT (W1C), 0x20 IRQ_EN (RW), 0x28 BRIGHT (see Configuration); all other offsets are unmapped.
REQ-016 SHALL pass each input bit through a 2-flop synchronizer, then a per-bit debouncer whose output takes the new value only after the synchronized bit differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the old value restarts the count.
REQ-017 SHALL make SWITCH and BUTTON reads return the debounced values, zero-extended.
REQ-018 SHALL set EVENT[i] sticky on a debounced button 0->1 edge; a write of 1 clears the bit; a set and a clear in the same cycle SHALL leave the bit set.
REQ-019 SHALL drive o_irq registered as |(EVENT & IRQ_EN[NUM_BUTTONS-1:0]), one cycle after the cause.
REQ-020 SHALL accept a write only when i_awvalid and i_wvalid are both high and no B response is pending, asserting o_awready and o_wready together for exactly one cycle.
REQ-021 SHALL assert o_bvalid the cycle after a write is accepted, with o_bid equal to the captured i_awid, holding o_bvalid and o_bid until i_bready.
REQ-022 SHALL apply writes per byte lane under i_wstrb; bits beyond a register's width SHALL be ignored.
REQ-023 SHALL accept a read with a one-cycle o_arready pulse when i_arvalid is high and no R response is pending, then assert o_rvalid the next cycle with o_rid equal to i_arid, holding o_rdata and o_rresp stable until i_rready.
REQ-024 SHALL answer accesses to RO or unmapped offsets with SLVERR (2'b10): writes have no effect, unmapped reads return 0, and RO reads return OKAY (2'b00) with data; all other accesses return OKAY.
REQ-025 SHALL handle a simultaneous read and write independently; a read of the same register in that cycle returns the pre-write value.
REQ-026 SHALL ignore i_awprot and i_arprot.

Reset
REQ-027 SHALL, while areset is low, asynchronously clear all of the following: o_awready, o_wready, o_bvalid, o_bid, o_bresp, o_arready, o_rvalid, o_rid, o_rdata, o_rresp, o_leds, o_irq, LED, EVENT, IRQ_EN, synchronizers, debounced values and debounce counters.
REQ-028 SHALL set BRIGHT to 8'hFF on reset.
REQ-029 SHALL abandon any pending B or R response when reset is asserted mid-transaction.
REQ-030 SHALL ensure that no EVENT bit is set by the first debounce after reset unless a true 0->1 edge occurs.

Configuration
REQ-031 SHALL, with macro NEXYS_BASIC_IO_PWM_EN defined, implement BRIGHT[7:0] (RW) and a free-running 8-bit counter, driving o_leds = LED & {NUM_LEDS{cnt < BRIGHT}}, so that 8'hFF gives 255/256 duty and 8'h00 gives off.
REQ-032 SHALL, with NEXYS_BASIC_IO_PWM_EN undefined, drive o_leds = LED directly and treat offset 0x28 as unmapped (SLVERR, read 0).

Verification
REQ-033 SHALL cover: write 0x00 data 0xA5 with strb 0x01 -> BRESP 00, o_leds = 0xA5 (PWM off), and a readback of 0xA5.
REQ-034 SHALL cover, with DEBOUNCE_CYCLES=4: i_switches 0x00->0x3C held -> SWITCH reads 0x3C no earlier than 2+4 cycles later; a 3-cycle glitch -> no change.
REQ-035 SHALL cover: IRQ_EN=0x01 and button0 pressed -> EVENT=0x01 and o_irq=1; W1C 0x01 -> EVENT=0 and o_irq=0 one cycle later.
REQ-036 SHALL cover: a write to 0x08 or a read of 0x30 -> resp 2'b10, read data 0, no state change.
REQ-037 SHALL cover: i_bready/i_rready held low for 10 cycles -> o_bvalid/o_rvalid, IDs and data held stable, and no second acceptance in that window.
REQ-038 SHALL cover, with PWM_EN defined: BRIGHT=0x40 and LED=0xFF -> o_leds high 64 of every 256 cycles.

Source files
------------

// File: rtl/nexys_video_basic_io_v2.sv
// Nexys Video buttons/switches/LEDs behind an AXI-Lite register slave with debouncing and button-event IRQ.
// Define NEXYS_BASIC_IO_PWM_EN to add the BRIGHT register and PWM dimming of the LEDs.
module nexys_video_basic_io_v2 #(
   parameter int AXI_ID_WIDTH    = 1,
   parameter int AXI_ADDR_WIDTH  = 64,
   parameter int AXI_DATA_WIDTH  = 64,
   parameter int NUM_BUTTONS     = 5,
   parameter int NUM_SWITCHES    = 8,
   parameter int NUM_LEDS        = 8,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic                        i_awvalid,
   output logic                        o_awready,
   input  logic [AXI_ID_WIDTH-1:0]     i_awid,
   input  logic [AXI_ADDR_WIDTH-1:0]   i_awaddr,
   input  logic [2:0]                  i_awprot,
   input  logic                        i_wvalid,
   output logic                        o_wready,
   input  logic [AXI_DATA_WIDTH-1:0]   i_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] i_wstrb,
   output logic                        o_bvalid,
   input  logic                        i_bready,
   output logic [AXI_ID_WIDTH-1:0]     o_bid,
   output logic [1:0]                  o_bresp,
   input  logic                        i_arvalid,
   output logic                        o_arready,
   input  logic [AXI_ID_WIDTH-1:0]     i_arid,
   input  logic [AXI_ADDR_WIDTH-1:0]   i_araddr,
   input  logic [2:0]                  i_arprot,
   output logic                        o_rvalid,
   input  logic                        i_rready,
   output logic [AXI_ID_WIDTH-1:0]     o_rid,
   output logic [AXI_DATA_WIDTH-1:0]   o_rdata,
   output logic [1:0]                  o_rresp,
   input  logic [NUM_BUTTONS-1:0]      i_buttons,
   input  logic [NUM_SWITCHES-1:0]     i_switches,
   output logic [NUM_LEDS-1:0]         o_leds,
   output logic                        o_irq
);

   localparam int NUM_IN = NUM_BUTTONS + NUM_SWITCHES;
   localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [2:0] OFS_LED    = 3'd0;
   localparam logic [2:0] OFS_SWITCH = 3'd1;
   localparam logic [2:0] OFS_BUTTON = 3'd2;
   localparam logic [2:0] OFS_EVENT  = 3'd3;
   localparam logic [2:0] OFS_IRQ_EN = 3'd4;
   localparam logic [2:0] OFS_BRIGHT = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   genvar gi;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
      return (old_val & ~mask) | (new_val & mask);
   endfunction

   logic [NUM_IN-1:0]       raw_in, sync1_reg, sync2_reg, deb_val, deb_rise;
   logic [NUM_BUTTONS-1:0]  btn_deb, armed_reg, event_reg, event_set, event_clr, irq_en_reg;
   logic [NUM_SWITCHES-1:0] sw_deb;
   logic [NUM_LEDS-1:0]     led_reg;
   logic [1:0]              fill_reg;
   logic                    sync_ok;

   assign raw_in  = {i_switches, i_buttons};
   assign btn_deb = deb_val[NUM_BUTTONS-1:0];
   assign sw_deb  = deb_val[NUM_IN-1:NUM_BUTTONS];
   assign sync_ok = (fill_reg == 2'd2);

   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         fill_reg  <= '0;
      end else begin
         sync1_reg <= raw_in;
         sync2_reg <= sync1_reg;
         if (!sync_ok) fill_reg <= fill_reg + 2'd1;
      end
   end

   for (gi = 0; gi < NUM_IN; gi++) begin : g_deb
      logic [CNT_W-1:0] cnt_reg;
      logic             deb_bit;
      assign deb_val[gi]  = deb_bit;
      assign deb_rise[gi] = (sync2_reg[gi] != deb_bit) && (cnt_reg == CNT_LAST) && sync2_reg[gi];
      always_ff @(posedge aclk or negedge areset) begin
         if (!areset) begin
            cnt_reg <= '0;
            deb_bit <= 1'b0;
         end else if (sync2_reg[gi] == deb_bit) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            deb_bit <= sync2_reg[gi];
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   // A button only generates events once it has been seen released after reset,
   // so a button held through reset does not fake a press.
   assign event_set = deb_rise[NUM_BUTTONS-1:0] & armed_reg;

   // ---------------- write channel ----------------
   logic [31:0] wdata32, wmask, led_wr, irq_en_wr, event_w1c;
   logic [2:0]  wr_ofs;
   logic        wr_fire, wr_ok;

   for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{i_wstrb[gi]}};
   end

   assign wdata32   = i_wdata[31:0];
   assign wr_ofs    = i_awaddr[5:3];
   assign wr_fire   = o_awready & i_awvalid & i_wvalid;
   assign led_wr    = lane_merge(32'(led_reg), wdata32, wmask);
   assign irq_en_wr = lane_merge(32'(irq_en_reg), wdata32, wmask);
   assign event_w1c = wdata32 & wmask;
   assign event_clr = (wr_fire && wr_ofs == OFS_EVENT) ? event_w1c[NUM_BUTTONS-1:0] : '0;

   always_comb begin
      wr_ok = 1'b0;
      case (wr_ofs)
         OFS_LED, OFS_EVENT, OFS_IRQ_EN: wr_ok = 1'b1;
`ifdef NEXYS_BASIC_IO_PWM_EN
         OFS_BRIGHT:                     wr_ok = 1'b1;
`endif
         default:                        wr_ok = 1'b0;
      endcase
   end

   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         o_awready  <= 1'b0;
         o_wready   <= 1'b0;
         o_bvalid   <= 1'b0;
         o_bid      <= '0;
         o_bresp    <= '0;
         led_reg    <= '0;
         irq_en_reg <= '0;
         event_reg  <= '0;
         armed_reg  <= '0;
         o_irq      <= 1'b0;
      end else begin
         o_awready <= i_awvalid & i_wvalid & ~o_bvalid & ~o_awready;
         o_wready  <= i_awvalid & i_wvalid & ~o_bvalid & ~o_awready;
         if (wr_fire) begin
            o_bvalid <= 1'b1;
            o_bid    <= i_awid;
            o_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (o_bvalid && i_bready) begin
            o_bvalid <= 1'b0;
         end
         if (wr_fire && wr_ofs == OFS_LED)    led_reg    <= led_wr[NUM_LEDS-1:0];
         if (wr_fire && wr_ofs == OFS_IRQ_EN) irq_en_reg <= irq_en_wr[NUM_BUTTONS-1:0];
         armed_reg <= armed_reg | ({NUM_BUTTONS{sync_ok}} & ~sync2_reg[NUM_BUTTONS-1:0] & ~btn_deb);
         event_reg <= (event_reg & ~event_clr) | event_set;
         o_irq     <= |(event_reg & irq_en_reg);
      end
   end

   // ---------------- brightness / LED drive ----------------
`ifdef NEXYS_BASIC_IO_PWM_EN
   logic [7:0]          bright_reg, pwm_cnt_reg;
   logic [NUM_LEDS-1:0] leds_reg;

   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         bright_reg  <= 8'hFF;
         pwm_cnt_reg <= '0;
         leds_reg    <= '0;
      end else begin
         pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
         leds_reg    <= led_reg & {NUM_LEDS{pwm_cnt_reg < bright_reg}};
         if (wr_fire && wr_ofs == OFS_BRIGHT)
            bright_reg <= (bright_reg & ~wmask[7:0]) | (wdata32[7:0] & wmask[7:0]);
      end
   end

   assign o_leds = leds_reg;
`else
   assign o_leds = led_reg;
`endif

   // ---------------- read channel ----------------
   logic [31:0] rd_val;
   logic [2:0]  rd_ofs;
   logic        rd_fire, rd_err;

   assign rd_ofs  = i_araddr[5:3];
   assign rd_fire = o_arready & i_arvalid;

   always_comb begin
      rd_val = '0;
      rd_err = 1'b0;
      case (rd_ofs)
         OFS_LED:    rd_val = 32'(led_reg);
         OFS_SWITCH: rd_val = 32'(sw_deb);
         OFS_BUTTON: rd_val = 32'(btn_deb);
         OFS_EVENT:  rd_val = 32'(event_reg);
         OFS_IRQ_EN: rd_val = 32'(irq_en_reg);
`ifdef NEXYS_BASIC_IO_PWM_EN
         OFS_BRIGHT: rd_val = {24'd0, bright_reg};
`endif
         default:    rd_err = 1'b1;
      endcase
   end

   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         o_arready <= 1'b0;
         o_rvalid  <= 1'b0;
         o_rid     <= '0;
         o_rdata   <= '0;
         o_rresp   <= '0;
      end else begin
         o_arready <= i_arvalid & ~o_rvalid & ~o_arready;
         if (rd_fire) begin
            o_rvalid <= 1'b1;
            o_rid    <= i_arid;
            o_rdata  <= AXI_DATA_WIDTH'(rd_val);
            o_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
         end else if (o_rvalid && i_rready) begin
            o_rvalid <= 1'b0;
         end
      end
   end

   // Bits that are intentionally not decoded (prot, upper address/data, switch rise).
   logic unused_bits;
   assign unused_bits = ^{i_awprot, i_arprot, i_awaddr, i_araddr, i_wdata, i_wstrb,
                          led_wr, irq_en_wr, event_w1c, deb_rise[NUM_IN-1:NUM_BUTTONS]};

endmodule

// File: tb/tb_nexys_video_basic_io_v2.sv
// Directed bench for nexys_video_basic_io_v2 (DEBOUNCE_CYCLES=4); PWM checks run when
// NEXYS_BASIC_IO_PWM_EN is defined, otherwise offset 0x28 is checked as unmapped.
module tb_nexys_video_basic_io_v2;

   logic        aclk = 1'b0;
   logic        areset = 1'b0;
   logic        i_awvalid = 0, i_wvalid = 0, i_bready = 1, i_arvalid = 0, i_rready = 1;
   logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_irq;
   logic [0:0]  i_awid = 0, i_arid = 0, o_bid, o_rid;
   logic [63:0] i_awaddr = 0, i_araddr = 0, i_wdata = 0, o_rdata;
   logic [2:0]  i_awprot = 0, i_arprot = 0;
   logic [7:0]  i_wstrb = 0;
   logic [1:0]  o_bresp, o_rresp;
   logic [4:0]  i_buttons = 0;
   logic [7:0]  i_switches = 0, o_leds;

   int n_vec = 0;
   int n_err = 0;

   always #5 aclk = ~aclk;

   nexys_video_basic_io_v2 #(.DEBOUNCE_CYCLES(4)) dut (
      .aclk(aclk), .areset(areset),
      .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awprot(i_awprot),
      .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
      .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
      .i_arvalid(i_arvalid), .o_arready(o_arready), .i_arid(i_arid), .i_araddr(i_araddr), .i_arprot(i_arprot),
      .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp),
      .i_buttons(i_buttons), .i_switches(i_switches), .o_leds(o_leds), .o_irq(o_irq)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic axi_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            input logic id, output logic [1:0] resp, output logic bid);
      i_awaddr = addr; i_wdata = data; i_wstrb = strb; i_awid = id;
      i_awvalid = 1; i_wvalid = 1;
      for (int t = 0; t < 20 && !o_awready; t++) cycles(1);
      check_val("aw_ready", {o_awready, o_wready}, 2'b11);
      cycles(1);
      i_awvalid = 0; i_wvalid = 0;
      for (int t = 0; t < 20 && !o_bvalid; t++) cycles(1);
      resp = o_bresp; bid = o_bid;
      cycles(1);
   endtask

   task automatic axi_read(input logic [63:0] addr, input logic id,
                           output logic [63:0] data, output logic [1:0] resp);
      i_araddr = addr; i_arid = id; i_arvalid = 1;
      for (int t = 0; t < 20 && !o_arready; t++) cycles(1);
      check_val("ar_ready", o_arready, 1'b1);
      cycles(1);
      i_arvalid = 0;
      for (int t = 0; t < 20 && !o_rvalid; t++) cycles(1);
      check_val("r_valid", o_rvalid, 1'b1);
      check_val("r_id", o_rid, id);
      data = o_rdata; resp = o_rresp;
      cycles(1);
   endtask

   logic [1:0]  resp;
   logic        bid;
   logic [63:0] rd;
   int          bad, hi, other;

   initial begin
      // ---- reset state ----
      cycles(3);
      check_val("rst_outs", {o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_irq}, 6'b0);
      check_val("rst_leds", o_leds, 8'h00);
      areset = 1;
      cycles(2);

      // ---- LED write/readback, byte lanes ----
      axi_write(64'h00, 64'hA5, 8'h01, 1'b1, resp, bid);
      check_val("led_bresp", resp, 2'b00);
      check_val("led_bid", bid, 1'b1);
`ifndef NEXYS_BASIC_IO_PWM_EN
      check_val("led_pins", o_leds, 8'hA5);
`endif
      axi_read(64'h00, 1'b0, rd, resp);
      check_val("led_rd", rd, 64'hA5);
      check_val("led_rresp", resp, 2'b00);
      axi_write(64'h00, 64'hFFFF_FF3C, 8'h00, 1'b0, resp, bid);
      axi_write(64'h00, 64'h1200, 8'h02, 1'b0, resp, bid);
      axi_read(64'h100, 1'b1, rd, resp);
      check_val("led_strb_alias", rd, 64'hA5);

      // ---- switch debounce ----
      i_switches = 8'h3C;
      cycles(3);
      axi_read(64'h08, 1'b0, rd, resp);
      check_val("sw_early", rd, 64'h00);
      cycles(10);
      axi_read(64'h08, 1'b0, rd, resp);
      check_val("sw_settled", rd, 64'h3C);
      check_val("sw_rresp", resp, 2'b00);
      i_switches = 8'h00;
      cycles(3);
      i_switches = 8'h3C;
      cycles(12);
      axi_read(64'h08, 1'b0, rd, resp);
      check_val("sw_glitch", rd, 64'h3C);

      // ---- B held while i_bready low ----
      axi_write(64'h00, 64'h5A, 8'h01, 1'b1, resp, bid);
      i_bready = 0;
      i_awaddr = 64'h00; i_wdata = 64'h5A; i_wstrb = 8'h01; i_awid = 1'b1;
      i_awvalid = 1; i_wvalid = 1;
      for (int t = 0; t < 20 && !o_awready; t++) cycles(1);
      check_val("bh_aw_ready", o_awready, 1'b1);
      cycles(1);
      i_wdata = 64'h11; i_awid = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         cycles(1);
         if (!o_bvalid || o_bid !== 1'b1 || o_bresp !== 2'b00 || o_awready) bad++;
      end
      check_val("b_hold", bad, 0);
      i_bready = 1;
      cycles(1);
      check_val("b_drop", o_bvalid, 1'b0);
      for (int t = 0; t < 20 && !o_awready; t++) cycles(1);
      check_val("bh_aw2", o_awready, 1'b1);
      cycles(1);
      i_awvalid = 0; i_wvalid = 0;
      check_val("b2_id", {o_bvalid, o_bid}, 2'b10);
      cycles(1);

      // ---- R held while i_rready low ----
      i_rready = 0;
      i_araddr = 64'h00; i_arid = 1'b1; i_arvalid = 1;
      for (int t = 0; t < 20 && !o_arready; t++) cycles(1);
      check_val("rh_ar_ready", o_arready, 1'b1);
      cycles(1);
      i_araddr = 64'h08; i_arid = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         cycles(1);
         if (!o_rvalid || o_rid !== 1'b1 || o_rdata !== 64'h11 || o_rresp !== 2'b00 || o_arready) bad++;
      end
      check_val("r_hold", bad, 0);
      i_rready = 1;
      cycles(1);
      check_val("r_drop", o_rvalid, 1'b0);
      for (int t = 0; t < 20 && !o_arready; t++) cycles(1);
      check_val("rh_ar2", o_arready, 1'b1);
      cycles(1);
      i_arvalid = 0;
      check_val("r2_data", o_rdata, 64'h3C);
      check_val("r2_id", o_rid, 1'b0);
      cycles(1);

      // ---- simultaneous read and write of LED ----
      i_awaddr = 64'h00; i_wdata = 64'h77; i_wstrb = 8'h01; i_awid = 0;
      i_araddr = 64'h00; i_arid = 0;
      i_awvalid = 1; i_wvalid = 1; i_arvalid = 1;
      for (int t = 0; t < 20 && !(o_awready && o_arready); t++) cycles(1);
      check_val("sim_ready", {o_awready, o_arready}, 2'b11);
      cycles(1);
      i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
      check_val("sim_old", o_rdata, 64'h11);
      check_val("sim_bresp", {o_bvalid, o_bresp}, 3'b100);
      cycles(1);
      axi_read(64'h00, 1'b0, rd, resp);
      check_val("sim_new", rd, 64'h77);

      // ---- RO / unmapped ----
      axi_write(64'h08, 64'hFF, 8'hFF, 1'b0, resp, bid);
      check_val("wr_ro_resp", resp, 2'b10);
      axi_read(64'h08, 1'b0, rd, resp);
      check_val("ro_unchanged", rd, 64'h3C);
      axi_read(64'h30, 1'b1, rd, resp);
      check_val("unm_rd", {resp, rd}, {2'b10, 64'h0});
      axi_write(64'h38, 64'hFF, 8'hFF, 1'b0, resp, bid);
      check_val("unm_wr_resp", resp, 2'b10);
      axi_read(64'h00, 1'b0, rd, resp);
      check_val("led_after_err", rd, 64'h77);

      // ---- button event / IRQ / W1C ----
      axi_write(64'h20, 64'h01, 8'h01, 1'b0, resp, bid);
      i_buttons = 5'h01;
      cycles(12);
      axi_read(64'h18, 1'b0, rd, resp);
      check_val("evt_set", rd, 64'h01);
      axi_read(64'h10, 1'b0, rd, resp);
      check_val("btn_rd", rd, 64'h01);
      check_val("irq_on", o_irq, 1'b1);
      axi_write(64'h18, 64'h01, 8'h01, 1'b0, resp, bid);
      check_val("w1c_resp", resp, 2'b00);
      check_val("irq_off", o_irq, 1'b0);
      axi_read(64'h18, 1'b0, rd, resp);
      check_val("evt_clr", rd, 64'h00);
      i_buttons = 5'h03;
      cycles(12);
      axi_read(64'h18, 1'b0, rd, resp);
      check_val("evt_btn1", rd, 64'h02);
      check_val("irq_masked", o_irq, 1'b0);

`ifdef NEXYS_BASIC_IO_PWM_EN
      // ---- PWM ----
      axi_read(64'h28, 1'b0, rd, resp);
      check_val("bright_rst", {resp, rd}, {2'b00, 64'hFF});
      axi_write(64'h28, 64'h40, 8'h01, 1'b0, resp, bid);
      axi_write(64'h00, 64'hFF, 8'h01, 1'b0, resp, bid);
      cycles(3);
      hi = 0; other = 0;
      for (int i = 0; i < 256; i++) begin
         if (o_leds == 8'hFF) hi++;
         else if (o_leds != 8'h00) other++;
         cycles(1);
      end
      check_val("pwm_high", hi, 64);
      check_val("pwm_other", other, 0);
`else
      axi_read(64'h28, 1'b0, rd, resp);
      check_val("bright_unm_rd", {resp, rd}, {2'b10, 64'h0});
      axi_write(64'h28, 64'h40, 8'h01, 1'b0, resp, bid);
      check_val("bright_unm_wr", resp, 2'b10);
`endif

      // ---- reset mid-transaction with buttons held ----
      i_bready = 0;
      axi_write(64'h20, 64'h1F, 8'h01, 1'b1, resp, bid);
      check_val("pend_b", o_bvalid, 1'b1);
      areset = 0;
      #1;
      check_val("rst_abandon", {o_bvalid, o_irq, o_leds}, 10'h0);
      cycles(3);
      i_bready = 1;
      areset = 1;
      cycles(20);
      axi_read(64'h18, 1'b0, rd, resp);
      check_val("rst_no_evt", rd, 64'h00);
      axi_read(64'h10, 1'b0, rd, resp);
      check_val("rst_btn_held", rd, 64'h03);
      i_buttons = 5'h00;
      cycles(12);
      i_buttons = 5'h01;
      cycles(12);
      axi_read(64'h18, 1'b0, rd, resp);
      check_val("evt_after_rel", rd, 64'h01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
